// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester and the register-slave map it drives.
//   state_t   : requester FSM states
//   ADDR_*    : register addresses of the arithmetic slave (op / A / B)
//   OP_*      : op register encodings
//   cnt_width : bit width needed by the ACCESS wait-state counter
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_OP = 2'b00;
    localparam logic [1:0] ADDR_A  = 2'b01;
    localparam logic [1:0] ADDR_B  = 2'b10;

    localparam logic [31:0] OP_SUM = 32'd0;
    localparam logic [31:0] OP_SUB = 32'd1;

    // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        int unsigned w;
        w = (timeout < 2) ? 1 : $clog2(timeout);
        return w;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS wait-state counter for the APB requester.
// Ports:
//   pclk    in  clock
//   preset  in  asynchronous active-low reset
//   clear   in  reset count to 0 (takes priority over enable)
//   enable  in  one more ACCESS cycle with pready low
//   expire  out high on the edge where this wait cycle is the TIMEOUT-th one
// TIMEOUT = 0 disables expiry entirely.
module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of earlier low-pready ACCESS edges, so matching
    // LAST means this edge is the TIMEOUT-th one.
    assign expire = (TIMEOUT != 0) && enable && (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: turns single-beat valid/ready commands into APB SETUP/ACCESS
// transfers and returns a one-cycle response strobe.
// Ports:
//   pclk, preset            clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   command handshake (ready only in IDLE)
//   cmd_write/addr/wdata    command payload
//   rsp_valid               one-cycle completion strobe
//   rsp_rdata               read data (0 for writes and timeouts)
//   rsp_timeout             transfer aborted because pready never came
//   psel/penable/pwrite/paddr/pwdata  registered APB request
//   prdata/pready           APB completer response
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    state_t              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic cnt_clear;
    logic cnt_enable;
    logic cnt_expire;

    assign cnt_clear  = (state_q == SETUP);
    assign cnt_enable = (state_q == ACCESS) && !pready;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .pclk   (pclk),
        .preset (preset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expire (cnt_expire)
    );

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;

        unique case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                // pready is not looked at until the ACCESS phase.
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready takes priority over expiry on the same edge.
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    state_d       = IDLE;
                end else if (cnt_expire) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;
    import apb_pkg::*;

    logic        pclk = 1'b0;
    logic        preset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_addr = 2'b00;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [1:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master #(
        .ADDR_W  (2),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready)
    );

    always #5 pclk = ~pclk;

    // Completer model: sum/sub register slave with a programmable number of wait states.
    int          wait_n = 0;
    int          acc_cnt = 0;
    logic [31:0] op_r = 32'd0;
    logic [31:0] a_r  = 32'd0;
    logic [31:0] b_r  = 32'd0;

    assign pready = psel && penable && (acc_cnt == wait_n);
    assign prdata = (paddr == ADDR_OP) ? ((op_r == OP_SUB) ? a_r - b_r : a_r + b_r) :
                    (paddr == ADDR_A)  ? a_r :
                    (paddr == ADDR_B)  ? b_r : 32'hA5A5_0011;

    always @(posedge pclk) begin
        if (psel && penable) begin
            if (pready) begin
                acc_cnt <= 0;
                if (pwrite) begin
                    case (paddr)
                        ADDR_OP: op_r <= pwdata;
                        ADDR_A:  a_r  <= pwdata;
                        ADDR_B:  b_r  <= pwdata;
                        default: ;
                    endcase
                end
            end else begin
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            acc_cnt <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        write;
        logic [1:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] exp_rdata;
        logic        exp_to;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    // Starts and ends on a falling edge; latency counts edges after the accept edge.
    task automatic run_vec(input vec_t v);
        int          lat;
        int          guard;
        logic        got;
        logic [31:0] exp_wd;
        exp_wd    = v.write ? v.wdata : 32'd0;
        wait_n    = v.waits;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 40) begin
            @(negedge pclk);
            guard++;
        end
        check("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        check("setup_psel", {31'd0, psel}, 32'd1);
        check("setup_penable", {31'd0, penable}, 32'd0);
        check("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            check("paddr_stable", {30'd0, paddr}, {30'd0, v.addr});
            check("pwrite_stable", {31'd0, pwrite}, {31'd0, v.write});
            check("pwdata_stable", pwdata, exp_wd);
            @(posedge pclk);
            #1;
            lat++;
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                check("access_psel", {31'd0, psel}, 32'd1);
                check("access_penable", {31'd0, penable}, 32'd1);
            end
        end
        check("rsp_seen", {31'd0, got}, 32'd1);
        check("rsp_latency", lat, v.exp_lat);
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, v.exp_to});
        check("done_psel", {31'd0, psel}, 32'd0);
        check("done_penable", {31'd0, penable}, 32'd0);
        check("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("hold_paddr", {30'd0, paddr}, {30'd0, v.addr});
        @(posedge pclk);
        #1;
        check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        @(negedge pclk);
    endtask

    vec_t b2b[4];
    int          rsp_cyc[4];
    logic [31:0] rsp_dat[4];
    logic        rsp_to[4];
    int          n_rsp;
    int          n_after;
    vec_t        post;

    initial begin
        vecs[0]  = '{1'b1, ADDR_A,  32'd7,         0,    32'd0,         1'b0, 2};
        vecs[1]  = '{1'b0, ADDR_A,  32'hFFFF_FFFF, 0,    32'd7,         1'b0, 2};
        vecs[2]  = '{1'b1, ADDR_B,  32'hDEAD_BEEF, 1,    32'd0,         1'b0, 3};
        vecs[3]  = '{1'b0, ADDR_B,  32'd0,         3,    32'hDEAD_BEEF, 1'b0, 5};
        vecs[4]  = '{1'b1, ADDR_OP, OP_SUM,        2,    32'd0,         1'b0, 4};
        vecs[5]  = '{1'b0, ADDR_OP, 32'd0,         0,    32'hDEAD_BEF6, 1'b0, 2};
        vecs[6]  = '{1'b0, 2'b11,   32'd0,         0,    32'hA5A5_0011, 1'b0, 2};
        vecs[7]  = '{1'b0, ADDR_A,  32'd0,         1000, 32'd0,         1'b1, 17};
        vecs[8]  = '{1'b0, ADDR_A,  32'd0,         0,    32'd7,         1'b0, 2};
        vecs[9]  = '{1'b0, ADDR_A,  32'd0,         15,   32'd7,         1'b0, 17};
        vecs[10] = '{1'b0, ADDR_B,  32'd0,         14,   32'hDEAD_BEEF, 1'b0, 16};
        vecs[11] = '{1'b1, ADDR_A,  32'd99,        16,   32'd0,         1'b1, 17};
        vecs[12] = '{1'b0, ADDR_A,  32'd0,         0,    32'd7,         1'b0, 2};

        b2b[0] = '{1'b1, ADDR_OP, OP_SUB, 0, 32'd0, 1'b0, 2};
        b2b[1] = '{1'b1, ADDR_A,  32'd10, 0, 32'd0, 1'b0, 2};
        b2b[2] = '{1'b1, ADDR_B,  32'd3,  0, 32'd0, 1'b0, 2};
        b2b[3] = '{1'b0, ADDR_OP, 32'd0,  0, 32'd7, 1'b0, 2};

        // Reset values.
        repeat (2) @(negedge pclk);
        check("rst_psel", {31'd0, psel}, 32'd0);
        check("rst_penable", {31'd0, penable}, 32'd0);
        check("rst_pwrite", {31'd0, pwrite}, 32'd0);
        check("rst_paddr", {30'd0, paddr}, 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        preset = 1'b1;
        repeat (2) @(negedge pclk);
        check("idle_psel", {31'd0, psel}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back commands with cmd_valid held high throughout.
        wait_n = 0;
        n_rsp  = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    int guard;
                    cmd_write = b2b[k].write;
                    cmd_addr  = b2b[k].addr;
                    cmd_wdata = b2b[k].wdata;
                    cmd_valid = 1'b1;
                    guard = 0;
                    while (!cmd_ready && guard < 20) begin
                        @(negedge pclk);
                        guard++;
                    end
                    check("b2b_accept", {31'd0, cmd_ready}, 32'd1);
                    @(posedge pclk);
                    #1;
                end
                cmd_valid = 1'b0;
            end
            begin
                for (int c = 1; c <= 25; c++) begin
                    @(posedge pclk);
                    #1;
                    if (rsp_valid) begin
                        if (n_rsp < 4) begin
                            rsp_cyc[n_rsp] = c;
                            rsp_dat[n_rsp] = rsp_rdata;
                            rsp_to[n_rsp]  = rsp_timeout;
                        end
                        n_rsp++;
                    end
                end
            end
        join
        check("b2b_rsp_count", n_rsp, 32'd4);
        if (n_rsp >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check("b2b_rdata", rsp_dat[k], b2b[k].exp_rdata);
                check("b2b_timeout", {31'd0, rsp_to[k]}, 32'd0);
                if (k > 0) begin
                    check("b2b_spacing", rsp_cyc[k] - rsp_cyc[k-1], 32'd3);
                end
            end
        end
        @(negedge pclk);

        // Reset asserted during an ACCESS wait state.
        wait_n    = 1000;
        cmd_write = 1'b0;
        cmd_addr  = ADDR_A;
        cmd_wdata = 32'd0;
        cmd_valid = 1'b1;
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge pclk);
        #1;
        check("pre_rst_penable", {31'd0, penable}, 32'd1);
        #2;
        preset = 1'b0;
        #1;
        check("async_rst_psel", {31'd0, psel}, 32'd0);
        check("async_rst_penable", {31'd0, penable}, 32'd0);
        check("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("async_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge pclk);
        preset = 1'b1;
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        n_after = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge pclk);
            #1;
            if (rsp_valid || psel) n_after++;
        end
        check("no_rsp_after_reset", n_after, 32'd0);
        @(negedge pclk);
        post = '{1'b0, ADDR_A, 32'd0, 0, 32'd10, 1'b0, 2};
        run_vec(post);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
